// File: rtl/trunc_level_sequencer.sv
// -----------------------------------------------------------------------------
// trunc_level_sequencer
//
// Sequences the truncation level of the approximate datapath. A level-change
// request holds new op issue, waits for in-flight ops to drain, applies the new
// select and its mask, then waits a settle window before releasing the
// datapath. Sweep mode steps the level from lo to hi, dwelling DWELL_OPS issued
// ops on each level, and pulses sweep_done_o once the top level has dwelt.
//
// Ports
//   wb_clk_i      clock
//   rst_n         asynchronous active-low reset
//   cfg_valid     level-change request
//   cfg_ready     request accepted when cfg_valid & cfg_ready (high only when idle)
//   cfg_sel       static: target level; sweep: upper level
//   cfg_lo        sweep: lower level (ignored for static requests)
//   cfg_sweep     1 = sweep request
//   op_start      one-cycle pulse per datapath op issued
//   dp_busy       datapath has ops in flight
//   hold_o        datapath must not issue ops while high
//   sel_o         applied truncation level
//   trunc_mask_o  registered mask matching sel_o
//   sel_valid_o   sel_o / trunc_mask_o stable and usable
//   sweep_done_o  one-cycle pulse when a sweep completes
// -----------------------------------------------------------------------------
module trunc_level_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DWELL_OPS     = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_sel,
    input  logic [3:0]  cfg_lo,
    input  logic        cfg_sweep,
    input  logic        op_start,
    input  logic        dp_busy,
    output logic        hold_o,
    output logic [3:0]  sel_o,
    output logic [31:0] trunc_mask_o,
    output logic        sel_valid_o,
    output logic        sweep_done_o
);

    typedef enum logic [1:0] {
        StActive,
        StDrain,
        StSettle
    } state_e;

    localparam logic [CNT_W-1:0] SettleInit = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] DwellLast  = CNT_W'(DWELL_OPS - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    // Mask width: odd k -> 2k+1 bits, even k -> 2k bits.
    function automatic logic [31:0] mask_for(input logic [3:0] k);
        logic [31:0] m;
        case (k)
            4'd0:    m = 32'h0000_0000;
            4'd1:    m = 32'h0000_0007;
            4'd2:    m = 32'h0000_000F;
            4'd3:    m = 32'h0000_007F;
            4'd4:    m = 32'h0000_00FF;
            4'd5:    m = 32'h0000_07FF;
            4'd6:    m = 32'h0000_0FFF;
            4'd7:    m = 32'h0000_7FFF;
            4'd8:    m = 32'h0000_FFFF;
            4'd9:    m = 32'h0007_FFFF;
            4'd10:   m = 32'h000F_FFFF;
            4'd11:   m = 32'h007F_FFFF;
            4'd12:   m = 32'h00FF_FFFF;
            4'd13:   m = 32'h07FF_FFFF;
            4'd14:   m = 32'h0FFF_FFFF;
            4'd15:   m = 32'h7FFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        mask_q, mask_d;
    logic [3:0]         target_q, target_d;
    logic [3:0]         hi_q, hi_d;
    logic               sweep_q, sweep_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic               done_q, done_d;
    logic               hold_q, hold_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        target_d = target_q;
        hi_d     = hi_q;
        sweep_d  = sweep_q;
        dwell_d  = dwell_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        hold_d   = hold_q;
        valid_d  = valid_q;
        ready_d  = ready_q;

        case (state_q)
            StActive: begin
                // A request accepted in the same cycle as a dwell expiry takes
                // precedence and silently aborts any running sweep.
                if (cfg_valid) begin
                    dwell_d = '0;
                    if (cfg_sweep && (cfg_lo <= cfg_sel)) begin
                        // Sweeps always go through drain/settle, even if already at lo.
                        sweep_d  = 1'b1;
                        hi_d     = cfg_sel;
                        target_d = cfg_lo;
                        state_d  = StDrain;
                        hold_d   = 1'b1;
                        valid_d  = 1'b0;
                        ready_d  = 1'b0;
                    end else begin
                        sweep_d = 1'b0;
                        if (cfg_sel != sel_q) begin
                            target_d = cfg_sel;
                            state_d  = StDrain;
                            hold_d   = 1'b1;
                            valid_d  = 1'b0;
                            ready_d  = 1'b0;
                        end
                    end
                end else if (sweep_q && op_start) begin
                    if (dwell_q == DwellLast) begin
                        dwell_d = '0;
                        if (sel_q < hi_q) begin
                            target_d = sel_q + 4'd1;
                            state_d  = StDrain;
                            hold_d   = 1'b1;
                            valid_d  = 1'b0;
                            ready_d  = 1'b0;
                        end else begin
                            done_d  = 1'b1;
                            sweep_d = 1'b0;
                        end
                    end else begin
                        dwell_d = dwell_q + CntOne;
                    end
                end
            end

            StDrain: begin
                if (!dp_busy) begin
                    sel_d  = target_q;
                    mask_d = mask_for(target_q);
                    if (SETTLE_CYCLES == 0) begin
                        state_d = StActive;
                        hold_d  = 1'b0;
                        valid_d = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        state_d  = StSettle;
                        settle_d = SettleInit;
                    end
                end
            end

            StSettle: begin
                settle_d = settle_q - CntOne;
                if (settle_q <= CntOne) begin
                    state_d = StActive;
                    hold_d  = 1'b0;
                    valid_d = 1'b1;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = StActive;
                hold_d  = 1'b0;
                valid_d = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StActive;
            sel_q    <= 4'd0;
            mask_q   <= 32'd0;
            target_q <= 4'd0;
            hi_q     <= 4'd0;
            sweep_q  <= 1'b0;
            dwell_q  <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            hold_q   <= 1'b0;
            valid_q  <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
            target_q <= target_d;
            hi_q     <= hi_d;
            sweep_q  <= sweep_d;
            dwell_q  <= dwell_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign cfg_ready    = ready_q;
    assign hold_o       = hold_q;
    assign sel_o        = sel_q;
    assign trunc_mask_o = mask_q;
    assign sel_valid_o  = valid_q;
    assign sweep_done_o = done_q;

endmodule

// File: tb/tb_trunc_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trunc_level_sequencer
//
// Directed bench for trunc_level_sequencer with a cycle-stamped behavioural
// model. Inputs change 2 time units after the rising edge; the model advances
// on the rising edge and every output is compared on the falling edge. Literal
// expectations at fixed points pin the model.
// -----------------------------------------------------------------------------
module tb_trunc_level_sequencer;

    localparam int SETTLE = 2;
    localparam int DWELL  = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_sel   = 4'd0;
    logic [3:0]  cfg_lo    = 4'd0;
    logic        cfg_sweep = 1'b0;
    logic        op_start  = 1'b0;
    logic        dp_busy   = 1'b0;
    logic        hold_o;
    logic [3:0]  sel_o;
    logic [31:0] trunc_mask_o;
    logic        sel_valid_o;
    logic        sweep_done_o;

    trunc_level_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .DWELL_OPS    (DWELL),
        .CNT_W        (16)
    ) dut (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_sel     (cfg_sel),
        .cfg_lo      (cfg_lo),
        .cfg_sweep   (cfg_sweep),
        .op_start    (op_start),
        .dp_busy     (dp_busy),
        .hold_o      (hold_o),
        .sel_o       (sel_o),
        .trunc_mask_o(trunc_mask_o),
        .sel_valid_o (sel_valid_o),
        .sweep_done_o(sweep_done_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mask straight from the level rule: 0 -> none, odd k -> 2k+1 bits, even k -> 2k bits.
    function automatic logic [31:0] spec_mask(input int k);
        int bits;
        if (k == 0)          bits = 0;
        else if (k % 2 == 1) bits = 2 * k + 1;
        else                 bits = 2 * k;
        return 32'((64'd1 << bits) - 64'd1);
    endfunction

    // ---------------- behavioural model ----------------
    int m_cyc     = 0;
    bit m_chg     = 1'b0;  // a level change is in progress (datapath held)
    bit m_wait    = 1'b0;  // still waiting for the datapath to empty
    int m_target  = 0;
    int m_sel     = 0;
    int m_release = 0;     // edge index at which the hold is released
    bit m_sw      = 1'b0;
    int m_hi      = 0;
    int m_ops     = 0;
    bit m_done    = 1'b0;

    task automatic begin_change(input int t);
        m_chg    = 1'b1;
        m_wait   = 1'b1;
        m_target = t;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_chg = 1'b0; m_wait = 1'b0; m_target = 0; m_sel = 0; m_release = 0;
            m_sw = 1'b0; m_hi = 0; m_ops = 0; m_done = 1'b0;
        end else begin
            m_cyc++;
            m_done = 1'b0;
            if (!m_chg) begin
                if (cfg_valid) begin
                    m_ops = 0;
                    if (cfg_sweep && (cfg_lo <= cfg_sel)) begin
                        m_sw = 1'b1;
                        m_hi = int'(cfg_sel);
                        begin_change(int'(cfg_lo));
                    end else begin
                        m_sw = 1'b0;
                        if (int'(cfg_sel) != m_sel) begin_change(int'(cfg_sel));
                    end
                end else if (m_sw && op_start) begin
                    m_ops++;
                    if (m_ops == DWELL) begin
                        m_ops = 0;
                        if (m_sel < m_hi) begin
                            begin_change(m_sel + 1);
                        end else begin
                            m_done = 1'b1;
                            m_sw   = 1'b0;
                        end
                    end
                end
            end else if (m_wait) begin
                if (!dp_busy) begin
                    m_sel  = m_target;
                    m_wait = 1'b0;
                    if (SETTLE == 0) m_chg = 1'b0;
                    else             m_release = m_cyc + SETTLE;
                end
            end else if (m_cyc >= m_release) begin
                m_chg = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("cmp_sel",   32'(sel_o),        32'(m_sel));
        check("cmp_mask",  trunc_mask_o,      spec_mask(m_sel));
        check("cmp_hold",  32'(hold_o),       32'(m_chg));
        check("cmp_valid", 32'(sel_valid_o),  32'(!m_chg));
        check("cmp_ready", 32'(cfg_ready),    32'(!m_chg));
        check("cmp_done",  32'(sweep_done_o), 32'(m_done));
        if (sweep_done_o === 1'b1) n_done++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (sel_valid_o !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        check(name, 32'(sel_valid_o), 32'd1);
    endtask

    task automatic ops(input int n);
        repeat (n) begin
            op_start = 1'b1;
            tick(1);
            op_start = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        logic [31:0] sweep_masks [3];
        int d0;
        sweep_masks[0] = 32'h0000_000F;
        sweep_masks[1] = 32'h0000_007F;
        sweep_masks[2] = 32'h0000_00FF;

        // 1: reset state
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("t1_sel",   32'(sel_o),        32'd0);
        check("t1_mask",  trunc_mask_o,      32'd0);
        check("t1_valid", 32'(sel_valid_o),  32'd1);
        check("t1_hold",  32'(hold_o),       32'd0);
        check("t1_ready", 32'(cfg_ready),    32'd1);
        check("t1_done",  32'(sweep_done_o), 32'd0);

        // 2: static change to 5, datapath idle
        cfg_sel = 4'd5; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        check("t2_hold_T1",  32'(hold_o),      32'd1);
        check("t2_ready_T1", 32'(cfg_ready),   32'd0);
        tick(1);
        check("t2_sel_T2",   32'(sel_o),       32'd5);
        check("t2_mask_T2",  trunc_mask_o,     32'h0000_07FF);
        check("t2_valid_T2", 32'(sel_valid_o), 32'd0);
        tick(1);
        check("t2_valid_T3", 32'(sel_valid_o), 32'd0);
        tick(1);
        check("t2_valid_T4", 32'(sel_valid_o), 32'd1);
        check("t2_hold_T4",  32'(hold_o),      32'd0);

        // 3: static change to 9 while the datapath stays busy
        cfg_sel = 4'd9; cfg_valid = 1'b1; dp_busy = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        repeat (6) begin
            check("t3_sel_busy",   32'(sel_o),     32'd5);
            check("t3_ready_busy", 32'(cfg_ready), 32'd0);
            tick(1);
        end
        dp_busy = 1'b0;
        tick(1);
        check("t3_sel",   32'(sel_o),     32'd9);
        check("t3_mask",  trunc_mask_o,   32'h0007_FFFF);
        check("t3_ready", 32'(cfg_ready), 32'd0);
        wait_valid("t3_release");

        // same-level static request causes no transition
        cfg_sel = 4'd9; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        check("t3b_hold", 32'(hold_o), 32'd0);
        check("t3b_sel",  32'(sel_o),  32'd9);

        // 4: sweep 2..4
        cfg_sweep = 1'b1; cfg_lo = 4'd2; cfg_sel = 4'd4; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0; cfg_sweep = 1'b0;
        d0 = n_done;
        for (int lvl = 2; lvl <= 4; lvl++) begin
            wait_valid("t4_release");
            check("t4_sel",  32'(sel_o),   32'(lvl));
            check("t4_mask", trunc_mask_o, sweep_masks[lvl-2]);
            ops(DWELL);
        end
        tick(2);
        check("t4_done_count", 32'(n_done - d0), 32'd1);
        check("t4_sel_end",    32'(sel_o),       32'd4);
        check("t4_valid_end",  32'(sel_valid_o), 32'd1);

        // 5: sweep 1..2 aborted by a request on the 16th dwell op
        cfg_sweep = 1'b1; cfg_lo = 4'd1; cfg_sel = 4'd2; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0; cfg_sweep = 1'b0;
        op_start = 1'b1;  // issued while held: must not count
        tick(2);
        op_start = 1'b0;
        wait_valid("t5_release");
        check("t5_sel_lo", 32'(sel_o), 32'd1);
        d0 = n_done;
        ops(DWELL - 1);
        check("t5_sel_pre", 32'(sel_o), 32'd1);
        op_start = 1'b1; cfg_valid = 1'b1; cfg_sel = 4'd3;
        tick(1);
        op_start = 1'b0; cfg_valid = 1'b0;
        wait_valid("t5_release2");
        check("t5_sel",  32'(sel_o),   32'd3);
        check("t5_mask", trunc_mask_o, 32'h0000_007F);
        ops(DWELL);
        tick(2);
        check("t5_sel_after",   32'(sel_o),       32'd3);
        check("t5_no_done",     32'(n_done - d0), 32'd0);

        // sweep with lo > hi is a static request to cfg_sel
        cfg_sweep = 1'b1; cfg_lo = 4'd6; cfg_sel = 4'd2; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0; cfg_sweep = 1'b0;
        wait_valid("t5b_release");
        check("t5b_sel", 32'(sel_o), 32'd2);
        ops(DWELL);
        check("t5b_sel_after", 32'(sel_o), 32'd2);

        // 6: asynchronous reset during settle of change to 15
        cfg_sel = 4'd15; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tick(2);
        check("t6_sel_settle",   32'(sel_o),       32'd15);
        check("t6_mask_settle",  trunc_mask_o,     32'h7FFF_FFFF);
        check("t6_valid_settle", 32'(sel_valid_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_sel",   32'(sel_o),       32'd0);
        check("t6_mask",  trunc_mask_o,     32'd0);
        check("t6_valid", 32'(sel_valid_o), 32'd1);
        check("t6_hold",  32'(hold_o),      32'd0);
        check("t6_ready", 32'(cfg_ready),   32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("t6_sel_post",   32'(sel_o),       32'd0);
        check("t6_valid_post", 32'(sel_valid_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
